// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-port round-robin write-back arbiter for the register file
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int N_SRC      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_SRC-1:0]                     req_valid_i,
    output logic [N_SRC-1:0]                     req_ready_o,
    input  logic [N_SRC-1:0][ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [N_SRC-1:0][DATA_WIDTH-1:0]     req_data_i,
    output logic                                 we_a_o,
    output logic [ADDR_WIDTH-1:0]                waddr_a_o,
    output logic [DATA_WIDTH-1:0]                wdata_a_o,
    output logic                                 we_b_o,
    output logic [ADDR_WIDTH-1:0]                waddr_b_o,
    output logic [DATA_WIDTH-1:0]                wdata_b_o,
    output logic                                 busy_o
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [PTR_W-1:0]      r_rr;
    logic                  r_we_a;
    logic                  r_we_b;
    logic [ADDR_WIDTH-1:0] r_waddr_a;
    logic [ADDR_WIDTH-1:0] r_waddr_b;
    logic [DATA_WIDTH-1:0] r_wdata_a;
    logic [DATA_WIDTH-1:0] r_wdata_b;
    logic                  r_busy;

    logic                  w_g0_vld;
    logic                  w_g1_vld;
    logic [PTR_W-1:0]      w_g0;
    logic [PTR_W-1:0]      w_g1;
    logic [PTR_W-1:0]      w_idx;
    logic [N_SRC-1:0]      w_ready;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_SRC) s = s - N_SRC;
        return PTR_W'(s);
    endfunction

    // One circular pass from r_rr: the first valid is g0, the next valid with a different address is g1.
    always_comb begin
        w_g0_vld = 1'b0;
        w_g1_vld = 1'b0;
        w_g0     = '0;
        w_g1     = '0;
        w_idx    = '0;
        w_ready  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            w_idx = wrap_add(r_rr, k);
            if (!w_g0_vld) begin
                if (req_valid_i[w_idx]) begin
                    w_g0_vld       = 1'b1;
                    w_g0           = w_idx;
                    w_ready[w_idx] = 1'b1;
                end
            end else if (!w_g1_vld && req_valid_i[w_idx] &&
                         (req_addr_i[w_idx] != req_addr_i[w_g0])) begin
                w_g1_vld       = 1'b1;
                w_g1           = w_idx;
                w_ready[w_idx] = 1'b1;
            end
        end
    end

    assign req_ready_o = w_ready & {N_SRC{rst_n}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr      <= '0;
            r_we_a    <= 1'b0;
            r_we_b    <= 1'b0;
            r_waddr_a <= '0;
            r_waddr_b <= '0;
            r_wdata_a <= '0;
            r_wdata_b <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_we_a <= w_g0_vld;
            r_we_b <= w_g1_vld;
            r_busy <= w_g0_vld;
            if (w_g0_vld) begin
                r_waddr_a <= req_addr_i[w_g0];
                r_wdata_a <= req_data_i[w_g0];
            end
            if (w_g1_vld) begin
                r_waddr_b <= req_addr_i[w_g1];
                r_wdata_b <= req_data_i[w_g1];
            end
            // g1 is always further along the scan than g0, so it sets the next start point.
            if (w_g1_vld)      r_rr <= wrap_add(w_g1, 1);
            else if (w_g0_vld) r_rr <= wrap_add(w_g0, 1);
        end
    end

    assign we_a_o    = r_we_a;
    assign we_b_o    = r_we_b;
    assign waddr_a_o = r_waddr_a;
    assign waddr_b_o = r_waddr_b;
    assign wdata_a_o = r_wdata_a;
    assign wdata_b_o = r_wdata_b;
    assign busy_o    = r_busy;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int N  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N-1:0]          valid;
    logic [N-1:0]          ready;
    logic [N-1:0][AW-1:0]  addr;
    logic [N-1:0][DW-1:0]  data;
    logic                  we_a, we_b, busy;
    logic [AW-1:0]         waddr_a, waddr_b;
    logic [DW-1:0]         wdata_a, wdata_b;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_SRC(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(valid), .req_ready_o(ready),
        .req_addr_i(addr), .req_data_i(data),
        .we_a_o(we_a), .waddr_a_o(waddr_a), .wdata_a_o(wdata_a),
        .we_b_o(we_b), .waddr_b_o(waddr_b), .wdata_b_o(wdata_b),
        .busy_o(busy)
    );

    typedef struct {
        logic          we_a;
        logic [AW-1:0] aa;
        logic [DW-1:0] da;
        logic          we_b;
        logic [AW-1:0] ab;
        logic [DW-1:0] db;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            failures = 0;
    int            m_rr;
    logic [AW-1:0] h_aa, h_ab;
    logic [DW-1:0] h_da, h_db;
    logic [DW-1:0] rf [0:(1<<AW)-1];
    logic [N-1:0]  m_grant;
    int            pending[logic [DW-1:0]];
    logic [DW-1:0] uniq;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_grant(output logic g0v, output int g0, output logic g1v, output int g1);
        int idx;
        g0v = 1'b0; g1v = 1'b0; g0 = 0; g1 = 0;
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (!g0v) begin
                if (valid[idx]) begin g0v = 1'b1; g0 = idx; end
            end else if (!g1v && valid[idx] && addr[idx] != addr[g0]) begin
                g1v = 1'b1; g1 = idx;
            end
        end
    endtask

    task automatic consume(input logic [DW-1:0] d, input string tag);
        int c;
        c = pending.exists(d) ? pending[d] : 0;
        chk(tag, (c > 0), 1'b1);
        if (c > 1) pending[d] = c - 1;
        else if (c == 1) pending.delete(d);
    endtask

    // Called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        logic g0v, g1v;
        int   g0, g1;
        exp_t e;
        #1;
        model_grant(g0v, g0, g1v, g1);
        m_grant = '0;
        if (g0v) m_grant[g0] = 1'b1;
        if (g1v) m_grant[g1] = 1'b1;
        chk("ready", ready, m_grant);
        if (g0v) begin
            h_aa = addr[g0]; h_da = data[g0];
            pending[data[g0]] = (pending.exists(data[g0]) ? pending[data[g0]] : 0) + 1;
        end
        if (g1v) begin
            h_ab = addr[g1]; h_db = data[g1];
            pending[data[g1]] = (pending.exists(data[g1]) ? pending[data[g1]] : 0) + 1;
        end
        e.we_a = g0v; e.aa = h_aa; e.da = h_da;
        e.we_b = g1v; e.ab = h_ab; e.db = h_db;
        sb.push_back(e);
        if (g1v) m_rr = (g1 + 1) % N;
        else if (g0v) m_rr = (g0 + 1) % N;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("we_a", we_a, e.we_a);
        chk("waddr_a", waddr_a, e.aa);
        chk("wdata_a", wdata_a, e.da);
        chk("we_b", we_b, e.we_b);
        chk("waddr_b", waddr_b, e.ab);
        chk("wdata_b", wdata_b, e.db);
        chk("busy", busy, e.we_a | e.we_b);
        chk("same_addr", (we_a && we_b && waddr_a == waddr_b), 1'b0);
        if (we_a) begin rf[waddr_a] = wdata_a; consume(wdata_a, "once_a"); end
        if (we_b) begin rf[waddr_b] = wdata_b; consume(wdata_b, "once_b"); end
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_rr = 0;
        h_aa = '0; h_ab = '0; h_da = '0; h_db = '0;
        sb.delete();
        pending.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        valid = '1;
        for (int i = 0; i < N; i++) begin
            addr[i] = AW'(i + 1);
            data[i] = 32'hA000_0000 + DW'(i);
        end
        model_reset();
        uniq = 32'h1000_0000;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", ready, 4'b0000);
        chk("rst_we_a", we_a, 1'b0);
        chk("rst_we_b", we_b, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_waddr_a", waddr_a, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // All valid, distinct addresses: pairs (0,1),(2,3),(0,1),(2,3).
        step();
        chk("first_a_src0", wdata_a, 32'hA000_0000);
        chk("first_b_src1", wdata_b, 32'hA000_0001);
        repeat (3) step();

        // Single source at rr=0.
        valid = 4'b0100;
        addr[2] = 5'd7; data[2] = 32'hDEAD_BEEF;
        step();
        chk("single_ready", m_grant, 4'b0100);
        chk("single_addr", waddr_a, 5'd7);
        chk("single_data", wdata_a, 32'hDEAD_BEEF);

        // Wrap from rr=3: src3 on A, src0 on B.
        valid = 4'b1001;
        addr[0] = 5'd11; data[0] = 32'h0000_0B00;
        addr[3] = 5'd12; data[3] = 32'h0000_0C03;
        step();
        chk("wrap_a", wdata_a, 32'h0000_0C03);
        chk("wrap_b", wdata_b, 32'h0000_0B00);

        // Bring rr back to 0, then a same-address conflict.
        valid = 4'b1000;
        step();
        valid = 4'b1011;
        addr[0] = 5'd5; data[0] = 32'h5555_0000;
        addr[1] = 5'd5; data[1] = 32'h5555_0001;
        addr[3] = 5'd9; data[3] = 32'h9999_0003;
        step();
        chk("conflict_grant", m_grant, 4'b1001);
        valid = 4'b0010;
        step();
        chk("conflict_late_a", wdata_a, 32'h5555_0001);
        chk("conflict_rf5", rf[5], 32'h5555_0001);

        // Reset while writes are being presented and another grant is pending.
        valid = '1;
        for (int i = 0; i < N; i++) addr[i] = AW'(16 + i);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_we_a", we_a, 1'b0);
        chk("async_we_b", we_b, 1'b0);
        chk("async_busy", busy, 1'b0);
        chk("async_ready", ready, 4'b0000);
        valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();
        chk("dropped_we_a", we_a, 1'b0);

        // Random stress: sources hold requests until accepted, addresses collide often.
        valid = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!valid[i] && ($urandom_range(0, 2) != 0)) begin
                    valid[i] = 1'b1;
                    addr[i]  = AW'($urandom_range(0, 3));
                    data[i]  = uniq;
                    uniq     = uniq + 1;
                end
            end
            step();
            valid = valid & ~m_grant;
        end
        valid = '0;
        repeat (2) step();
        chk("drain", pending.num(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Write-back arbiter placed directly upstream of the 2-read/2-write register file.
- Collects write-back requests from N_SRC producers (ALU, LSU, MUL, DMA, ...) over valid/ready handshakes.
- Grants at most two per cycle using round-robin fairness and drives the register file's two write ports (A, B) from an output register stage.
- Guarantees the two ports never target the same address in the same cycle, so register-file port priority is never relied on.

Parameters:
ADDR_WIDTH, 5, register address width; must match the register file.
DATA_WIDTH, 32, write data width.
N_SRC, 4, number of requesters; must be >= 2. Pointer width is $clog2(N_SRC).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid_i  in  N_SRC  per-source write request valid
req_ready_o  out  N_SRC  per-source grant; a transfer occurs when valid && ready
req_addr_i  in  N_SRC x ADDR_WIDTH  per-source destination address
req_data_i  in  N_SRC x DATA_WIDTH  per-source write data
we_a_o  out  1  port A write enable
waddr_a_o  out  ADDR_WIDTH  port A address
wdata_a_o  out  DATA_WIDTH  port A data
we_b_o  out  1  port B write enable
waddr_b_o  out  ADDR_WIDTH  port B address
wdata_b_o  out  DATA_WIDTH  port B data
busy_o  out  1  high when either we_a_o or we_b_o is high (registered)

Behaviour:
- Reset (async assert, sync-release on clk):
  - rr_q = 0.
  - we_a_o = we_b_o = 0, all addr/data outputs = 0, busy_o = 0.
  - req_ready_o = 0 while rst_n is low.
- Grant 0 (g0): first index i with req_valid_i[i] = 1, scanning rr_q, rr_q+1, ... modulo N_SRC.
- Grant 1 (g1):
  - First valid index after g0, continuing the same circular scan and stopping before returning to rr_q.
  - Its req_addr_i must differ from req_addr_i[g0]; any same-address requester is skipped and the scan continues.
- req_ready_o:
  - Combinational; bit i is high iff i is g0 or g1.
  - Ready depends on valid. Sources must not make valid depend on ready.
- Latency:
  - A request granted in cycle t appears on the write port at cycle t+1.
  - g0 drives port A (we_a_o = 1, waddr_a_o, wdata_a_o). g1 drives port B.
  - With no g1, we_b_o = 0. With no grant at all, both enables are 0.
- Data-path outputs: addr/data hold their last value when the corresponding enable is 0.
- Round-robin pointer update:
  - If g1 exists: rr_q <= (g1+1) mod N_SRC.
  - Else if g0 exists: rr_q <= (g0+1) mod N_SRC.
  - Else: rr_q holds.
- Same-address conflict:
  - The skipped requester keeps valid and waits; it is granted in a later cycle, so its write lands after the granted one.
  - Per-source ordering is preserved because each source issues one request per accepted handshake.
- Invariant: never we_a_o && we_b_o && (waddr_a_o == waddr_b_o).
- Single valid requester: it is always g0 (port A), one write per cycle, pointer advances past it.
- Wrap-around: scanning and pointer update are modulo N_SRC. g1's scan may wrap past N_SRC-1 to 0 but never reaches rr_q again.
- Reset mid-operation:
  - Output enables clear immediately (async).
  - Any write registered but not yet presented is dropped.
  - Sources must re-present requests after reset.
- Fairness bound: a continuously valid source is granted within ceil(N_SRC/2) cycles. Exception: repeated same-address conflicts, where the bound is N_SRC cycles.
- No internal FIFO. Throughput is up to 2 writes per cycle.

Test Plan:
- Reset check: hold rst_n=0 with all valid=1 -> req_ready_o=0000, we_a_o=we_b_o=0. Release -> first cycle grants src0 (A) and src1 (B); next cycle we_a_o=1 with src0 addr/data.
- Single source: src2 valid, addr=7, data=0xDEADBEEF, rr_q=0 -> ready=0100; next cycle we_a_o=1, waddr_a_o=7, wdata_a_o=0xDEADBEEF, we_b_o=0; rr_q=3.
- All four valid, distinct addresses, held for 4 cycles -> grant pairs (0,1),(2,3),(0,1),(2,3); each source gets 2 writes; port writes appear one cycle after each grant.
- Conflict: src0 and src1 both addr=5, src3 addr=9, rr_q=0 -> grants src0 (A) and src3 (B), src1 stalls. Next cycle (rr_q=0) src1 is granted on port A, so the final register content at addr 5 is src1's data.
- Wrap: rr_q=3, src3 and src0 valid -> g0=3, g1=0, rr_q becomes 1.
- Async reset asserted while grants are issuing -> enables drop to 0 without waiting for clk. The in-flight write is not presented after release. Random stress runs with a register-file model check the same-address invariant and that every accepted write appears exactly once.
